rx_frame_buf: RTL

- Store-and-forward frame buffer directly downstream of the 100G RX lane stage.
- Accepts the 256-bit data words, 40-bit ctrl words and write strobe that the RX stage produces.
- Commits only complete, well-formed frames (SOF through EOF). Frames that are aborted, orphaned, or overflow the buffer are discarded.
- Presents committed words to the frame parser through a valid/ready interface with end-of-frame byte counts.

---
 rtl/rx_frame_buf.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/rx_frame_buf.sv
// Store-and-forward RX frame buffer: commits only complete SOF..EOF frames and
// streams committed words to the parser over a valid/ready interface.
module rx_frame_buf #(
  parameter int AW    = 6,
  parameter int CNT_W = 16
) (
  input  logic             x_clk,
  input  logic             reset_,
  input  logic [255:0]     rx_data,
  input  logic [39:0]      rx_ctrl,
  input  logic             rx_we,
  input  logic             linkup,
  output logic [255:0]     m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_sof,
  output logic             m_eof,
  output logic [5:0]       m_bcnt,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             ovf
);

  localparam int WW = 256 + 1 + 1 + 6;
  localparam logic [AW:0] PTR_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  typedef enum logic [1:0] {IDLE, FRAME, DROP} state_t;

  state_t          state, state_nxt;
  logic [AW:0]     wr_ptr, wr_nxt, commit_ptr, commit_nxt, rd_ptr, used, waddr;
  logic [WW-1:0]   mem [2**AW];
  logic [WW-1:0]   rd_word;
  logic [5:0]      eof_bcnt;
  logic            sof, eof, full, start_ok, load;
  logic            mem_we, w_sof, w_eof, frame_inc, drop_inc, ovf_nxt;
  logic            ctrl_unused;

  assign ctrl_unused = ^{rx_ctrl[39:36], rx_ctrl[34], rx_ctrl[32]};
  assign sof         = rx_ctrl[33];
  assign eof         = rx_ctrl[35];
  assign used        = wr_ptr - rd_ptr;
  // used never exceeds DEPTH, so its MSB alone marks the full condition
  assign full        = used[AW];
  assign start_ok    = sof && (state == IDLE || (state == DROP && linkup));

  always_comb begin
    eof_bcnt = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (rx_ctrl[31-i] && rx_data[8*(31-i) +: 8] == 8'hFD)
        eof_bcnt = 6'(31 - i);
    end
  end

  always_comb begin
    state_nxt  = state;
    wr_nxt     = wr_ptr;
    commit_nxt = commit_ptr;
    waddr      = wr_ptr;
    mem_we     = 1'b0;
    w_sof      = 1'b0;
    w_eof      = 1'b0;
    frame_inc  = 1'b0;
    drop_inc   = 1'b0;
    ovf_nxt    = 1'b0;
    if (rx_we) begin
      if (state == FRAME) begin
        if (!linkup) begin
          wr_nxt    = commit_ptr;
          drop_inc  = 1'b1;
          state_nxt = DROP;
        end else if (sof) begin
          // restart a new frame over the aborted one's slots
          drop_inc = 1'b1;
          waddr    = commit_ptr;
          mem_we   = 1'b1;
          w_sof    = 1'b1;
          wr_nxt   = commit_ptr + PTR_ONE;
          if (eof) begin
            w_eof      = 1'b1;
            commit_nxt = commit_ptr + PTR_ONE;
            frame_inc  = 1'b1;
            state_nxt  = IDLE;
          end
        end else if (full) begin
          wr_nxt    = commit_ptr;
          drop_inc  = 1'b1;
          ovf_nxt   = 1'b1;
          state_nxt = DROP;
        end else if (eof) begin
          mem_we     = 1'b1;
          w_eof      = 1'b1;
          wr_nxt     = wr_ptr + PTR_ONE;
          commit_nxt = wr_ptr + PTR_ONE;
          frame_inc  = 1'b1;
          state_nxt  = IDLE;
        end else begin
          mem_we = 1'b1;
          wr_nxt = wr_ptr + PTR_ONE;
        end
      end else if (start_ok) begin
        if (full) begin
          drop_inc  = 1'b1;
          ovf_nxt   = 1'b1;
          state_nxt = DROP;
        end else begin
          mem_we    = 1'b1;
          w_sof     = 1'b1;
          wr_nxt    = wr_ptr + PTR_ONE;
          state_nxt = FRAME;
          if (eof) begin
            w_eof      = 1'b1;
            commit_nxt = wr_ptr + PTR_ONE;
            frame_inc  = 1'b1;
            state_nxt  = IDLE;
          end
        end
      end
    end
  end

  always_ff @(posedge x_clk or negedge reset_) begin
    if (!reset_) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      frame_cnt  <= '0;
      drop_cnt   <= '0;
      ovf        <= 1'b0;
    end else begin
      state      <= state_nxt;
      wr_ptr     <= wr_nxt;
      commit_ptr <= commit_nxt;
      ovf        <= ovf_nxt;
      if (frame_inc && frame_cnt != '1) frame_cnt <= frame_cnt + CNT_ONE;
      if (drop_inc && drop_cnt != '1)   drop_cnt  <= drop_cnt + CNT_ONE;
    end
  end

  always_ff @(posedge x_clk) begin
    if (mem_we)
      mem[waddr[AW-1:0]] <= {rx_data, w_sof, w_eof, w_eof ? eof_bcnt : 6'd32};
  end

  assign rd_word = mem[rd_ptr[AW-1:0]];
  assign load    = (rd_ptr != commit_ptr) && (!m_valid || m_ready);

  always_ff @(posedge x_clk or negedge reset_) begin
    if (!reset_) begin
      rd_ptr  <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_sof   <= 1'b0;
      m_eof   <= 1'b0;
      m_bcnt  <= '0;
    end else if (load) begin
      rd_ptr  <= rd_ptr + PTR_ONE;
      m_valid <= 1'b1;
      m_data  <= rd_word[WW-1 -: 256];
      m_sof   <= rd_word[7];
      m_eof   <= rd_word[6];
      m_bcnt  <= rd_word[5:0];
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule
